load_bin: RTL and testbench
===========================

# load_bin

Loads one bin from the bin RAMs into the SAT engine. It is the upstream counterpart of the bin write-back stage. On `start_load` it streams the bin's data in three sequential read phases:
- clauses from the clause-bin RAM;
- variable states, fetched indirectly through the var-bin RAM;
- level states.

Each item is delivered to the engine as a registered data word plus a one-hot slot strobe. `apply_load_o` is held high for the whole load so the top level can steer the BRAM muxes to this block.

## Interface
- NUM_CLAUSES_A_BIN, 8, clause slots per bin
- NUM_VARS_A_BIN, 8, var slots per bin
- NUM_LVLS_A_BIN, 8, level slots per bin
- WIDTH_CLAUSES, NUM_VARS_A_BIN*2, clause word width
- WIDTH_VARS, 12, global var id width
- WIDTH_LVL, 16, level number width
- WIDTH_BIN_ID, 10, bin id width
- WIDTH_VAR_STATES / WIDTH_LVL_STATES, 30 / 30, state word widths
- ADDR_WIDTH_CLAUSES / _VARS / _VARS_STATES / _LVLS_STATES, 9 each, RAM address widths
- Reset and clock (already decided): reset `rst`, synchronous, active-low; clock `clk`.
- clk  in  1  clock
- rst  in  1  reset
- start_load  in  1  load request pulse; only honoured in IDLE
- cur_bin_num_i  in  WIDTH_BIN_ID  bin to load
- base_lvl_i  in  WIDTH_LVL  first global level of the bin
- busy_o  out  1  high whenever state != IDLE
- apply_load_o  out  1  high in LOAD_C, LOAD_V and LOAD_L
- done_load  out  1  one-cycle pulse, high while in DONE
- wr_carray_o  out  NUM_CLAUSES_A_BIN  one-hot clause-slot strobe
- clause_o  out  WIDTH_CLAUSES  clause data
- wr_var_states_o  out  NUM_VARS_A_BIN  one-hot var-slot strobe
- var_state_o  out  WIDTH_VAR_STATES  var state data
- wr_lvl_states_o  out  NUM_LVLS_A_BIN  one-hot level-slot strobe
- lvl_state_o  out  WIDTH_LVL_STATES  level state data
- ram_addr_c_o out ADDR_WIDTH_CLAUSES; ram_data_c_i in WIDTH_CLAUSES
- ram_addr_v_o out ADDR_WIDTH_VARS; ram_data_v_i in WIDTH_VARS
- ram_addr_vs_o out ADDR_WIDTH_VARS_STATES; ram_data_vs_i in WIDTH_VAR_STATES
- ram_addr_l_state_o out ADDR_WIDTH_LVLS_STATES; ram_data_l_state_i in WIDTH_LVL_STATES

## Operation
- States and transitions: IDLE → LOAD_C → LOAD_V → LOAD_L → DONE → IDLE.
- Latching: `cur_bin_num_i` and `base_lvl_i` are captured on the `start_load` edge. Later changes to those inputs are ignored.
- `start_load` outside IDLE is ignored.
- All RAMs have 1-cycle read latency. Every output is registered.
- LOAD_C:
  - Address k (k = 0..NUM_C-1) is `bin*NUM_CLAUSES_A_BIN + k`, issued in state-cycle k.
  - `wr_carray_o[k]` and `clause_o` are high/valid in state-cycle k+2.
- LOAD_V, addressing:
  - Var-bin address is `bin*NUM_VARS_A_BIN + k`, issued in state-cycle k.
  - `ram_addr_vs_o` takes the returned var id in state-cycle k+2.
  - `wr_var_states_o[k]` and `var_state_o` are valid in state-cycle k+4.
- LOAD_V, empty slot: var id 0 means an empty slot. The strobe still fires for that slot, but `var_state_o` = 0 and the RAM data is discarded.
- LOAD_L:
  - Address is `base_lvl + k`, issued in state-cycle k.
  - Strobe/data are valid in state-cycle k+2.
- Phase lengths: each phase ends on the cycle its last strobe is driven. LOAD_C lasts NUM_C+2 cycles, LOAD_V lasts NUM_V+4, LOAD_L lasts NUM_L+2.
- Arithmetic: all address sums are modulo 2^ADDR_WIDTH and wrap silently.
- Idle values: strobes, data and addresses are 0 whenever no strobe/address is active.
- Reset values: all outputs 0, state IDLE.
- Reset mid-load returns the block to IDLE within one cycle, with no further strobes.

## Timing
- Counting from the `start_load` edge (cycle 0 is the first LOAD_C cycle):
  - `done_load` is high in cycle NUM_C+NUM_V+NUM_L+8, which is 32 with the defaults.
  - Exactly one strobe bit across all three strobe buses is high per cycle at most.
- A new `start_load` is accepted in the cycle after DONE.

## Configuration
- Macro `LOAD_BIN_LVL_STATES_EN`.
- Defined: the LOAD_L phase runs as described.
- Undefined:
  - LOAD_V goes directly to DONE.
  - `wr_lvl_states_o`, `lvl_state_o` and `ram_addr_l_state_o` are tied to 0.
  - `done_load` moves to cycle NUM_C+NUM_V+6 (22 with the defaults).

## Structure
- Package `load_bin_pkg` holds:
  - the state enum;
  - phase latency constants (C_LAT=2, V_LAT=4, L_LAT=2).
- Sub-module `bin_rd_seq` is a parameterised address counter plus a delayed one-hot strobe shifter, with parameters N and LAT. It is instantiated once per phase.

## Test plan
- Bin 3, clause RAM addr 24+k holds 0xA0+k → `wr_carray_o` = 1<<k with `clause_o` = 0xA0+k in cycles 2..9; `done_load` in cycle 32.
- Var-bin slot 2 holds id 0, other slots hold ids 100+k with var state 0x1000+k → slot 2 strobes with data 0; slot 5 gives 0x1005 in cycle 10+4+5 = 19.
- `base_lvl_i` = 510 with 9-bit address → level addresses 510, 511, 0, … wrap; data is delivered in order.
- `start_load` pulsed again during LOAD_V → ignored; a single `done_load`; load data unchanged.
- `rst` low in LOAD_C cycle 4 → the next cycle is IDLE, all outputs 0; a following `start_load` completes normally.
- Macro undefined → no level strobes, `done_load` in cycle 22.

Source files
------------

// File: rtl/load_bin_pkg.sv
// Shared constants and state type for the bin loader (load_bin).
package load_bin_pkg;

    localparam int NUM_CLAUSES_A_BIN      = 8;
    localparam int NUM_VARS_A_BIN         = 8;
    localparam int NUM_LVLS_A_BIN         = 8;
    localparam int WIDTH_CLAUSES          = NUM_VARS_A_BIN * 2;
    localparam int WIDTH_VARS             = 12;
    localparam int WIDTH_LVL              = 16;
    localparam int WIDTH_BIN_ID           = 10;
    localparam int WIDTH_VAR_STATES       = 30;
    localparam int WIDTH_LVL_STATES       = 30;
    localparam int ADDR_WIDTH_CLAUSES     = 9;
    localparam int ADDR_WIDTH_VARS        = 9;
    localparam int ADDR_WIDTH_VARS_STATES = 9;
    localparam int ADDR_WIDTH_LVLS_STATES = 9;

    // Cycles from issuing a slot address to driving that slot's strobe
    localparam int C_LAT = 2;
    localparam int V_LAT = 4;
    localparam int L_LAT = 2;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_C,
        LOAD_V,
        LOAD_L,
        DONE
    } state_t;

endpackage

// File: rtl/load_bin_if.sv
// Bin RAM read ports and engine write strobes/data seen by load_bin.
interface load_bin_if;
    import load_bin_pkg::*;

    logic [ADDR_WIDTH_CLAUSES-1:0]     ram_addr_c_o;
    logic [WIDTH_CLAUSES-1:0]          ram_data_c_i;
    logic [ADDR_WIDTH_VARS-1:0]        ram_addr_v_o;
    logic [WIDTH_VARS-1:0]             ram_data_v_i;
    logic [ADDR_WIDTH_VARS_STATES-1:0] ram_addr_vs_o;
    logic [WIDTH_VAR_STATES-1:0]       ram_data_vs_i;
    logic [ADDR_WIDTH_LVLS_STATES-1:0] ram_addr_l_state_o;
    logic [WIDTH_LVL_STATES-1:0]       ram_data_l_state_i;

    logic [NUM_CLAUSES_A_BIN-1:0]      wr_carray_o;
    logic [WIDTH_CLAUSES-1:0]          clause_o;
    logic [NUM_VARS_A_BIN-1:0]         wr_var_states_o;
    logic [WIDTH_VAR_STATES-1:0]       var_state_o;
    logic [NUM_LVLS_A_BIN-1:0]         wr_lvl_states_o;
    logic [WIDTH_LVL_STATES-1:0]       lvl_state_o;

    modport master (
        output ram_addr_c_o, ram_addr_v_o, ram_addr_vs_o, ram_addr_l_state_o,
        output wr_carray_o, clause_o, wr_var_states_o, var_state_o,
        output wr_lvl_states_o, lvl_state_o,
        input  ram_data_c_i, ram_data_v_i, ram_data_vs_i, ram_data_l_state_i
    );

    modport slave (
        input  ram_addr_c_o, ram_addr_v_o, ram_addr_vs_o, ram_addr_l_state_o,
        input  wr_carray_o, clause_o, wr_var_states_o, var_state_o,
        input  wr_lvl_states_o, lvl_state_o,
        output ram_data_c_i, ram_data_v_i, ram_data_vs_i, ram_data_l_state_i
    );

endinterface

// File: rtl/load_bin_rd_seq.sv
// bin_rd_seq: per-phase address counter (N slots from a base address) plus a
// one-hot slot strobe delayed LAT cycles behind each issued address.
module bin_rd_seq #(
    parameter int N   = 8,
    parameter int LAT = 2,
    parameter int AW  = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base,
    output logic [AW-1:0] addr_o,
    output logic          issue_o,
    output logic [N-1:0]  strobe_o,
    output logic          last_o
);

    logic [N-1:0] issue_oh;
    logic [N-1:0] next_oh;
    logic [N-1:0] pipe [LAT];

    assign next_oh = issue_oh << 1;

    // issue_oh marks the slot whose address is on addr_o this cycle;
    // addresses wrap modulo 2^AW and fall back to 0 once the slots run out
    always_ff @(posedge clk) begin
        if (!rst) begin
            issue_oh <= '0;
            addr_o   <= '0;
            for (int i = 0; i < LAT; i++) pipe[i] <= '0;
        end else begin
            if (start) begin
                issue_oh <= N'(1);
                addr_o   <= base;
            end else begin
                issue_oh <= next_oh;
                addr_o   <= (|next_oh) ? addr_o + AW'(1) : '0;
            end
            pipe[0] <= issue_oh;
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign issue_o  = |issue_oh;
    assign strobe_o = pipe[LAT-1];
    assign last_o   = pipe[LAT-1][N-1];

endmodule

// File: rtl/load_bin.sv
// load_bin: streams one bin (clauses, indirect var states, level states) from
// the bin RAMs into the SAT engine. Macro LOAD_BIN_LVL_STATES_EN enables LOAD_L.
module load_bin
    import load_bin_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_load,
    input  logic [WIDTH_BIN_ID-1:0] cur_bin_num_i,
    input  logic [WIDTH_LVL-1:0]    base_lvl_i,
    output logic                    busy_o,
    output logic                    apply_load_o,
    output logic                    done_load,
    load_bin_if.master              bus
);

    state_t state, next_state;
    logic start_c, start_v;
    logic c_issue, c_last, v_issue, v_last;
    logic c_vld1, v_vld1, v_vld2, v_vld3, v_empty2, v_empty3;
    logic [WIDTH_BIN_ID-1:0] bin_q;
    logic [ADDR_WIDTH_CLAUSES-1:0] c_base;
    logic [ADDR_WIDTH_VARS-1:0]    v_base;

    assign c_base = ADDR_WIDTH_CLAUSES'(cur_bin_num_i * WIDTH_BIN_ID'(NUM_CLAUSES_A_BIN));
    assign v_base = ADDR_WIDTH_VARS'(bin_q * WIDTH_BIN_ID'(NUM_VARS_A_BIN));

`ifdef LOAD_BIN_LVL_STATES_EN
    logic start_l, l_issue, l_last, l_vld1;
    logic [ADDR_WIDTH_LVLS_STATES-1:0] lvl_q;
    logic unused_lvl_hi;
    assign unused_lvl_hi = ^base_lvl_i[WIDTH_LVL-1:ADDR_WIDTH_LVLS_STATES];
`else
    logic unused_lvl;
    assign unused_lvl = ^{base_lvl_i, bus.ram_data_l_state_i};
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            busy_o       <= 1'b0;
            apply_load_o <= 1'b0;
            done_load    <= 1'b0;
            bin_q        <= '0;
        end else begin
            state        <= next_state;
            busy_o       <= (next_state != IDLE);
            apply_load_o <= (next_state == LOAD_C) || (next_state == LOAD_V) ||
                            (next_state == LOAD_L);
            done_load    <= (next_state == DONE);
            if (start_c) bin_q <= cur_bin_num_i;
        end
    end

    // Each phase hands over on the cycle its last slot strobe is driven
    always_comb begin
        next_state = state;
        start_c    = 1'b0;
        start_v    = 1'b0;
`ifdef LOAD_BIN_LVL_STATES_EN
        start_l    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (start_load) begin
                    next_state = LOAD_C;
                    start_c    = 1'b1;
                end
            end
            LOAD_C: begin
                if (c_last) begin
                    next_state = LOAD_V;
                    start_v    = 1'b1;
                end
            end
            LOAD_V: begin
                if (v_last) begin
`ifdef LOAD_BIN_LVL_STATES_EN
                    next_state = LOAD_L;
                    start_l    = 1'b1;
`else
                    next_state = DONE;
`endif
                end
            end
`ifdef LOAD_BIN_LVL_STATES_EN
            LOAD_L: begin
                if (l_last) next_state = DONE;
            end
`endif
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    bin_rd_seq #(.N(NUM_CLAUSES_A_BIN), .LAT(C_LAT), .AW(ADDR_WIDTH_CLAUSES)) u_seq_c (
        .clk      (clk),
        .rst      (rst),
        .start    (start_c),
        .base     (c_base),
        .addr_o   (bus.ram_addr_c_o),
        .issue_o  (c_issue),
        .strobe_o (bus.wr_carray_o),
        .last_o   (c_last)
    );

    bin_rd_seq #(.N(NUM_VARS_A_BIN), .LAT(V_LAT), .AW(ADDR_WIDTH_VARS)) u_seq_v (
        .clk      (clk),
        .rst      (rst),
        .start    (start_v),
        .base     (v_base),
        .addr_o   (bus.ram_addr_v_o),
        .issue_o  (v_issue),
        .strobe_o (bus.wr_var_states_o),
        .last_o   (v_last)
    );

    // Var id 0 marks an empty slot: its state word is forced to 0 two cycles on
    always_ff @(posedge clk) begin
        if (!rst) begin
            c_vld1            <= 1'b0;
            bus.clause_o      <= '0;
            v_vld1            <= 1'b0;
            v_vld2            <= 1'b0;
            v_vld3            <= 1'b0;
            v_empty2          <= 1'b0;
            v_empty3          <= 1'b0;
            bus.ram_addr_vs_o <= '0;
            bus.var_state_o   <= '0;
        end else begin
            c_vld1            <= c_issue;
            bus.clause_o      <= c_vld1 ? bus.ram_data_c_i : '0;
            v_vld1            <= v_issue;
            v_vld2            <= v_vld1;
            v_vld3            <= v_vld2;
            v_empty2          <= v_vld1 && (bus.ram_data_v_i == '0);
            v_empty3          <= v_empty2;
            bus.ram_addr_vs_o <= v_vld1 ? ADDR_WIDTH_VARS_STATES'(bus.ram_data_v_i) : '0;
            bus.var_state_o   <= (v_vld3 && !v_empty3) ? bus.ram_data_vs_i : '0;
        end
    end

`ifdef LOAD_BIN_LVL_STATES_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            lvl_q           <= '0;
            l_vld1          <= 1'b0;
            bus.lvl_state_o <= '0;
        end else begin
            if (start_c) lvl_q <= base_lvl_i[ADDR_WIDTH_LVLS_STATES-1:0];
            l_vld1          <= l_issue;
            bus.lvl_state_o <= l_vld1 ? bus.ram_data_l_state_i : '0;
        end
    end

    bin_rd_seq #(.N(NUM_LVLS_A_BIN), .LAT(L_LAT), .AW(ADDR_WIDTH_LVLS_STATES)) u_seq_l (
        .clk      (clk),
        .rst      (rst),
        .start    (start_l),
        .base     (lvl_q),
        .addr_o   (bus.ram_addr_l_state_o),
        .issue_o  (l_issue),
        .strobe_o (bus.wr_lvl_states_o),
        .last_o   (l_last)
    );
`else
    assign bus.ram_addr_l_state_o = '0;
    assign bus.wr_lvl_states_o    = '0;
    assign bus.lvl_state_o        = '0;
`endif

endmodule

// File: tb/tb_load_bin.sv
// Self-checking bench for load_bin: RAM models plus a per-cycle expected-output
// table built from the load rules (follows LOAD_BIN_LVL_STATES_EN like the DUT).
module tb_load_bin;
    import load_bin_pkg::*;

    localparam int NC = 8;
    localparam int NV = 8;
    localparam int NL = 8;
    localparam int V0 = NC + 2;
    localparam int L0 = V0 + NV + 4;
`ifdef LOAD_BIN_LVL_STATES_EN
    localparam int DONE_CYC = L0 + NL + 2;
    localparam int DONE_LIT = 32;
`else
    localparam int DONE_CYC = L0;
    localparam int DONE_LIT = 22;
`endif
    localparam int NCYC = DONE_CYC + 4;

    typedef struct packed {
        logic [7:0]  wc;
        logic [7:0]  wv;
        logic [7:0]  wl;
        logic [15:0] cl;
        logic [29:0] vs;
        logic [29:0] ls;
        logic [8:0]  ac;
        logic [8:0]  av;
        logic [8:0]  avs;
        logic [8:0]  al;
        logic        done;
        logic        busy;
        logic        apply;
    } snap_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_load = 1'b0;
    logic [9:0]  cur_bin = '0;
    logic [15:0] base_lvl = '0;
    logic        busy, apply, done;

    int tests_run = 0;
    int tests_failed = 0;

    logic [15:0] clause_mem [512];
    logic [11:0] var_mem    [512];
    logic [29:0] vs_mem     [512];
    logic [29:0] lvl_mem    [512];

    snap_t obs   [NCYC];
    snap_t ref_s [NCYC];

    load_bin_if bus ();

    load_bin dut (
        .clk           (clk),
        .rst           (rst),
        .start_load    (start_load),
        .cur_bin_num_i (cur_bin),
        .base_lvl_i    (base_lvl),
        .busy_o        (busy),
        .apply_load_o  (apply),
        .done_load     (done),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAMs with one cycle of latency
    always @(posedge clk) begin
        bus.ram_data_c_i       <= clause_mem[bus.ram_addr_c_o];
        bus.ram_data_v_i       <= var_mem[bus.ram_addr_v_o];
        bus.ram_data_vs_i      <= vs_mem[bus.ram_addr_vs_o];
        bus.ram_data_l_state_i <= lvl_mem[bus.ram_addr_l_state_o];
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic snap_t sample_now();
        snap_t s;
        s.wc = bus.wr_carray_o;   s.wv = bus.wr_var_states_o; s.wl = bus.wr_lvl_states_o;
        s.cl = bus.clause_o;      s.vs = bus.var_state_o;     s.ls = bus.lvl_state_o;
        s.ac = bus.ram_addr_c_o;  s.av = bus.ram_addr_v_o;
        s.avs = bus.ram_addr_vs_o; s.al = bus.ram_addr_l_state_o;
        s.done = done; s.busy = busy; s.apply = apply;
        return s;
    endfunction

    // Expected outputs per cycle, cycle 0 being the first cycle after the start edge
    task automatic build_model(input int bin, input int lvl);
        int a, id;
        for (int c = 0; c < NCYC; c++) ref_s[c] = '0;
        for (int c = 0; c <= DONE_CYC; c++) ref_s[c].busy = 1'b1;
        for (int c = 0; c < DONE_CYC; c++) ref_s[c].apply = 1'b1;
        ref_s[DONE_CYC].done = 1'b1;
        for (int k = 0; k < NC; k++) begin
            a = (bin * NC + k) % 512;
            ref_s[k].ac     = 9'(a);
            ref_s[k + 2].wc = 8'(1 << k);
            ref_s[k + 2].cl = clause_mem[a];
        end
        for (int k = 0; k < NV; k++) begin
            a  = (bin * NV + k) % 512;
            id = int'(var_mem[a]);
            ref_s[V0 + k].av      = 9'(a);
            ref_s[V0 + k + 2].avs = 9'(id % 512);
            ref_s[V0 + k + 4].wv  = 8'(1 << k);
            ref_s[V0 + k + 4].vs  = (id == 0) ? 30'd0 : vs_mem[id % 512];
        end
`ifdef LOAD_BIN_LVL_STATES_EN
        for (int k = 0; k < NL; k++) begin
            a = (lvl + k) % 512;
            ref_s[L0 + k].al     = 9'(a);
            ref_s[L0 + k + 2].wl = 8'(1 << k);
            ref_s[L0 + k + 2].ls = lvl_mem[a];
        end
`endif
    endtask

    // Pulses start_load for one edge, then records outputs for NCYC cycles;
    // a second start with different bin/level is pulsed at pulse_cyc if >= 0
    task automatic capture_load(input int bin, input int lvl, input int pulse_cyc);
        @(negedge clk);
        start_load = 1'b1;
        cur_bin    = 10'(bin);
        base_lvl   = 16'(lvl);
        @(negedge clk);
        start_load = 1'b0;
        for (int c = 0; c < NCYC; c++) begin
            obs[c] = sample_now();
            if (c == pulse_cyc) begin
                start_load = 1'b1;
                cur_bin    = ~cur_bin;
                base_lvl   = base_lvl + 16'd7;
            end else begin
                start_load = 1'b0;
            end
            @(negedge clk);
        end
        start_load = 1'b0;
    endtask

    task automatic test_reset;
        snap_t s;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        s = sample_now();
        tests_run++;
        if (s !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_held got=%h exp=0", s);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        s = sample_now();
        tests_run++;
        if (s !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_released_idle got=%h exp=0", s);
        end
    endtask

    task automatic test_clause_phase;
        for (int k = 0; k < NC; k++) clause_mem[24 + k] = 16'(16'hA0 + k);
        build_model(3, 40);
        capture_load(3, 40, -1);
        for (int c = 0; c < NCYC; c++) begin
            tests_run++;
            if ({obs[c].wc, obs[c].cl, obs[c].ac} !== {ref_s[c].wc, ref_s[c].cl, ref_s[c].ac}) begin
                tests_failed++;
                $display("[TB] FAIL clause_phase cyc=%0d got wc=%h cl=%h ac=%0d exp wc=%h cl=%h ac=%0d",
                         c, obs[c].wc, obs[c].cl, obs[c].ac, ref_s[c].wc, ref_s[c].cl, ref_s[c].ac);
            end
            tests_run++;
            if ({obs[c].done, obs[c].busy, obs[c].apply} !== {ref_s[c].done, ref_s[c].busy, ref_s[c].apply}) begin
                tests_failed++;
                $display("[TB] FAIL control cyc=%0d got done/busy/apply=%b%b%b exp=%b%b%b",
                         c, obs[c].done, obs[c].busy, obs[c].apply,
                         ref_s[c].done, ref_s[c].busy, ref_s[c].apply);
            end
        end
        tests_run++;
        if (obs[2].wc !== 8'h01 || obs[2].cl !== 16'hA0 || obs[9].wc !== 8'h80 || obs[9].cl !== 16'hA7) begin
            tests_failed++;
            $display("[TB] FAIL clause_literal got c2=%h/%h c9=%h/%h exp 01/a0 80/a7",
                     obs[2].wc, obs[2].cl, obs[9].wc, obs[9].cl);
        end
        tests_run++;
        if (obs[DONE_LIT].done !== 1'b1 || obs[DONE_LIT + 1].done !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL done_cycle got done[%0d]=%b done[+1]=%b exp 1 0",
                     DONE_LIT, obs[DONE_LIT].done, obs[DONE_LIT + 1].done);
        end
    endtask

    task automatic test_var_phase;
        for (int k = 0; k < NV; k++) begin
            var_mem[24 + k]  = (k == 2) ? 12'd0 : 12'(100 + k);
            vs_mem[100 + k]  = 30'(30'h1000 + k);
        end
        vs_mem[0] = 30'h3ABCDEF;
        build_model(3, 77);
        capture_load(3, 77, -1);
        for (int c = 0; c < NCYC; c++) begin
            tests_run++;
            if ({obs[c].wv, obs[c].vs, obs[c].av, obs[c].avs} !==
                {ref_s[c].wv, ref_s[c].vs, ref_s[c].av, ref_s[c].avs}) begin
                tests_failed++;
                $display("[TB] FAIL var_phase cyc=%0d got wv=%h vs=%h av=%0d avs=%0d exp wv=%h vs=%h av=%0d avs=%0d",
                         c, obs[c].wv, obs[c].vs, obs[c].av, obs[c].avs,
                         ref_s[c].wv, ref_s[c].vs, ref_s[c].av, ref_s[c].avs);
            end
        end
        tests_run++;
        if (obs[16].wv !== 8'h04 || obs[16].vs !== 30'd0) begin
            tests_failed++;
            $display("[TB] FAIL var_empty_slot got wv=%h vs=%h exp 04 0", obs[16].wv, obs[16].vs);
        end
        tests_run++;
        if (obs[19].wv !== 8'h20 || obs[19].vs !== 30'h1005) begin
            tests_failed++;
            $display("[TB] FAIL var_slot5 got wv=%h vs=%h exp 20 1005", obs[19].wv, obs[19].vs);
        end
    endtask

    task automatic test_lvl_wrap;
        build_model(9, 510);
        capture_load(9, 510, -1);
        for (int c = 0; c < NCYC; c++) begin
            tests_run++;
            if ({obs[c].wl, obs[c].ls, obs[c].al} !== {ref_s[c].wl, ref_s[c].ls, ref_s[c].al}) begin
                tests_failed++;
                $display("[TB] FAIL lvl_phase cyc=%0d got wl=%h ls=%h al=%0d exp wl=%h ls=%h al=%0d",
                         c, obs[c].wl, obs[c].ls, obs[c].al, ref_s[c].wl, ref_s[c].ls, ref_s[c].al);
            end
        end
`ifdef LOAD_BIN_LVL_STATES_EN
        tests_run++;
        if (obs[L0].al !== 9'd510 || obs[L0 + 1].al !== 9'd511 || obs[L0 + 2].al !== 9'd0) begin
            tests_failed++;
            $display("[TB] FAIL lvl_addr_wrap got %0d %0d %0d exp 510 511 0",
                     obs[L0].al, obs[L0 + 1].al, obs[L0 + 2].al);
        end
`else
        tests_run++;
        if (obs[L0].al !== 9'd0 || obs[L0 + 2].wl !== 8'd0) begin
            tests_failed++;
            $display("[TB] FAIL lvl_tied_off got al=%0d wl=%h exp 0 0", obs[L0].al, obs[L0 + 2].wl);
        end
`endif
    endtask

    task automatic test_restart_ignored;
        int dones;
        build_model(12, 200);
        capture_load(12, 200, 14);
        dones = 0;
        for (int c = 0; c < NCYC; c++) begin
            if (obs[c].done === 1'b1) dones++;
            tests_run++;
            if (obs[c] !== ref_s[c]) begin
                tests_failed++;
                $display("[TB] FAIL restart_ignored cyc=%0d got=%h exp=%h", c, obs[c], ref_s[c]);
            end
        end
        tests_run++;
        if (dones != 1) begin
            tests_failed++;
            $display("[TB] FAIL single_done got=%0d exp=1", dones);
        end
    endtask

    task automatic test_reset_midload;
        snap_t s;
        @(negedge clk);
        start_load = 1'b1;
        cur_bin    = 10'd5;
        base_lvl   = 16'd3;
        @(negedge clk);
        start_load = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 12; c++) begin
            s = sample_now();
            tests_run++;
            if (s !== '0) begin
                tests_failed++;
                $display("[TB] FAIL reset_midload cyc=%0d got=%h exp=0", c, s);
            end
            @(negedge clk);
        end
        build_model(5, 3);
        capture_load(5, 3, -1);
        for (int c = 0; c < NCYC; c++) begin
            tests_run++;
            if (obs[c] !== ref_s[c]) begin
                tests_failed++;
                $display("[TB] FAIL load_after_reset cyc=%0d got=%h exp=%h", c, obs[c], ref_s[c]);
            end
        end
    endtask

    task automatic test_random_loads;
        int bin, lvl;
        for (int n = 0; n < 6; n++) begin
            bin = int'($urandom_range(1023));
            lvl = int'($urandom_range(65535));
            build_model(bin, lvl);
            capture_load(bin, lvl, -1);
            for (int c = 0; c < NCYC; c++) begin
                tests_run++;
                if (obs[c] !== ref_s[c]) begin
                    tests_failed++;
                    $display("[TB] FAIL random_load%0d cyc=%0d got=%h exp=%h", n, c, obs[c], ref_s[c]);
                end
                tests_run++;
                if ($countones({obs[c].wc, obs[c].wv, obs[c].wl}) > 1) begin
                    tests_failed++;
                    $display("[TB] FAIL onehot_strobes cyc=%0d got=%h/%h/%h exp at most one bit",
                             c, obs[c].wc, obs[c].wv, obs[c].wl);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) begin
            clause_mem[i] = 16'($urandom);
            var_mem[i]    = ($urandom_range(3) == 0) ? 12'd0 : 12'($urandom);
            vs_mem[i]     = 30'($urandom);
            lvl_mem[i]    = 30'($urandom);
        end
        test_reset();
        test_clause_phase();
        test_var_phase();
        test_lvl_wrap();
        test_restart_ignored();
        test_reset_midload();
        test_random_loads();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
